// File: rtl/nuc_search_ctrl_if.sv
// Bundle for nuc_search_ctrl: the search request and results, and the read port to nucleotide memory.
// The abort input exists only when NUC_SEARCH_ABORT_EN is defined.
interface nuc_search_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic [7:0]        pattern;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] nuc_addr;
  logic              nuc_re;
  logic [1:0]        nuc_data;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] match_count;
`ifdef NUC_SEARCH_ABORT_EN
  logic              abort;

  modport master (
    output start, pattern, last_addr, nuc_data, abort,
    input  nuc_addr, nuc_re, busy, done, found, first_addr, match_count
  );
  modport slave (
    input  start, pattern, last_addr, nuc_data, abort,
    output nuc_addr, nuc_re, busy, done, found, first_addr, match_count
  );
`else
  modport master (
    output start, pattern, last_addr, nuc_data,
    input  nuc_addr, nuc_re, busy, done, found, first_addr, match_count
  );
  modport slave (
    input  start, pattern, last_addr, nuc_data,
    output nuc_addr, nuc_re, busy, done, found, first_addr, match_count
  );
`endif
endinterface

// File: rtl/nuc_search_ctrl.sv
// Scans nucleotide memory 0..last_addr for a 4-nucleotide pattern, counting overlapping matches.
// Optional feature: define NUC_SEARCH_ABORT_EN to add an abort input that ends a scan early.
module nuc_search_ctrl #(
  parameter int ADDR_W = 16
) (
  input logic             clock,
  input logic             reset_L,
  nuc_search_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_pattern;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [5:0]        r_window;
  logic [1:0]        r_fill;
  logic              r_found;
  logic [ADDR_W-1:0] r_first_addr;
  logic [ADDR_W-1:0] r_match_count;

  logic              w_scan;
  logic              w_stop;
  logic [7:0]        w_window_next;
  logic              w_match;

  assign w_scan        = (r_state == S_SCAN);
  assign w_window_next = {r_window, bus.nuc_data};
  // The window only holds a full pattern once three earlier nucleotides have been shifted in.
  assign w_match       = w_scan && (r_fill == 2'd3) && (w_window_next == r_pattern);

`ifdef NUC_SEARCH_ABORT_EN
  assign w_stop = (r_addr == r_last_addr) || bus.abort;
`else
  assign w_stop = (r_addr == r_last_addr);
`endif

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset_L) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SCAN;
      S_SCAN:  if (w_stop)    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: registered state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      r_pattern     <= '0;
      r_last_addr   <= '0;
      r_addr        <= '0;
      r_window      <= '0;
      r_fill        <= '0;
      r_found       <= 1'b0;
      r_first_addr  <= '0;
      r_match_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pattern     <= bus.pattern;
            r_last_addr   <= bus.last_addr;
            r_addr        <= '0;
            r_window      <= '0;
            r_fill        <= '0;
            r_found       <= 1'b0;
            r_first_addr  <= '0;
            r_match_count <= '0;
          end
        end
        S_SCAN: begin
          r_window <= w_window_next[5:0];
          r_addr   <= r_addr + 1'b1;
          if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
          if (w_match) begin
            r_match_count <= r_match_count + 1'b1;
            if (!r_found) begin
              r_found      <= 1'b1;
              r_first_addr <= r_addr - ADDR_W'(3);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.nuc_re      = w_scan;
  assign bus.nuc_addr    = w_scan ? r_addr : '0;
  assign bus.busy        = w_scan;
  assign bus.done        = (r_state == S_DONE);
  assign bus.found       = r_found;
  assign bus.first_addr  = r_first_addr;
  assign bus.match_count = r_match_count;

endmodule

// File: tb/tb_nuc_search_ctrl.sv
// Self-checking bench for nuc_search_ctrl: expected results are queued at start and compared at done.
// Define NUC_SEARCH_ABORT_EN for both files to exercise the abort scenario as well.
module tb_nuc_search_ctrl;

  localparam int ADDR_W = 16;

  typedef struct {
    logic              found;
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] count;
    int                latency;
  } exp_t;

  logic       clock;
  logic       reset_L;
  logic [1:0] mem [0:127];
  exp_t       sb_q[$];
  int         n_cmp;
  int         n_err;

  nuc_search_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  nuc_search_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational memory read model.
  always_comb bus.nuc_data = mem[bus.nuc_addr[6:0]];

  // Independent reference: slide over every start position 0..last-3.
  function automatic exp_t model(input logic [7:0] pat, input int last);
    exp_t e;
    e.found = 1'b0; e.first = '0; e.count = '0; e.latency = last + 2;
    for (int i = 0; i + 3 <= last; i++) begin
      if ({mem[i], mem[i+1], mem[i+2], mem[i+3]} == pat) begin
        if (!e.found) e.first = ADDR_W'(i);
        e.found = 1'b1;
        e.count = e.count + 1'b1;
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic f, input int first, input int cnt, input int lat);
    exp_t e;
    e.found = f; e.first = ADDR_W'(first); e.count = ADDR_W'(cnt); e.latency = lat;
    return e;
  endfunction

  task automatic fill_mem_random();
    for (int i = 0; i < 128; i++) mem[i] = 2'($urandom_range(0, 3));
  endtask

  // Called right after a negedge; returns right after a negedge.
  task automatic run_search(input string name, input logic [7:0] pat, input int last, input exp_t e);
    exp_t x;
    int   cyc, re_cnt, addr_bad;
    bus.start     = 1'b1;
    bus.pattern   = pat;
    bus.last_addr = ADDR_W'(last);
    sb_q.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1; re_cnt = 0; addr_bad = 0;
    while (bus.done !== 1'b1 && cyc <= last + 10) begin
      if (bus.nuc_re === 1'b1) begin
        re_cnt++;
        if (bus.nuc_addr !== ADDR_W'(cyc - 1)) addr_bad++;
      end
      @(negedge clock);
      cyc++;
    end
    x = sb_q.pop_front();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, cyc);
      return;
    end
    n_cmp++; if (cyc !== x.latency) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, x.latency); end
    n_cmp++; if (bus.found !== x.found) begin n_err++; $display("FAIL %s found: got %0b expected %0b", name, bus.found, x.found); end
    n_cmp++; if (bus.first_addr !== x.first) begin n_err++; $display("FAIL %s first_addr: got %0d expected %0d", name, bus.first_addr, x.first); end
    n_cmp++; if (bus.match_count !== x.count) begin n_err++; $display("FAIL %s match_count: got %0d expected %0d", name, bus.match_count, x.count); end
    n_cmp++; if (re_cnt !== last + 1) begin n_err++; $display("FAIL %s nuc_re cycles: got %0d expected %0d", name, re_cnt, last + 1); end
    n_cmp++; if (addr_bad !== 0) begin n_err++; $display("FAIL %s nuc_addr sequence: %0d wrong addresses", name, addr_bad); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s busy in DONE: got %0b expected 0", name, bus.busy); end
    @(negedge clock);
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL %s done pulse width: got %0b expected 0", name, bus.done); end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (bus.found !== x.found || bus.first_addr !== x.first || bus.match_count !== x.count) begin
      n_err++;
      $display("FAIL %s hold: got %0b/%0d/%0d expected %0b/%0d/%0d", name,
               bus.found, bus.first_addr, bus.match_count, x.found, x.first, x.count);
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.found !== 1'b0 || bus.first_addr !== '0 ||
        bus.match_count !== '0 || bus.nuc_re !== 1'b0 || bus.nuc_addr !== '0) begin
      n_err++;
      $display("FAIL %s outputs: busy=%0b done=%0b found=%0b first=%0d count=%0d re=%0b addr=%0d expected all 0",
               name, bus.busy, bus.done, bus.found, bus.first_addr, bus.match_count, bus.nuc_re, bus.nuc_addr);
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    bus.start = 1'b1;
    bus.pattern = 8'h00;
    bus.last_addr = ADDR_W'(5);
    repeat (3) @(negedge clock);
    check_idle_zero("reset");
    bus.start = 1'b0;
    reset_L = 1'b1;
    @(negedge clock);
    check_idle_zero("after_reset");
  endtask

  task automatic test_acgt();
    for (int i = 0; i < 128; i++) mem[i] = 2'(i % 4);
    run_search("acgt", 8'b00011011, 7, mk(1'b1, 0, 2, 9));
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    run_search("overlap", 8'h00, 5, mk(1'b1, 0, 3, 7));
  endtask

  task automatic test_short();
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    run_search("short_last2", 8'h00, 2, mk(1'b0, 0, 0, 4));
    run_search("short_last0", 8'h00, 0, mk(1'b0, 0, 0, 2));
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int         last, pos;
      logic [7:0] pat;
      fill_mem_random();
      last = $urandom_range(3, 60);
      pos  = $urandom_range(0, last - 3);
      pat  = {mem[pos], mem[pos+1], mem[pos+2], mem[pos+3]};
      if (t == 5) pat = 8'($urandom);
      run_search($sformatf("random%0d", t), pat, last, model(pat, last));
    end
  endtask

  task automatic test_reset_mid_scan();
    int done_cnt;
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    bus.start = 1'b1; bus.pattern = 8'h00; bus.last_addr = ADDR_W'(20);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.match_count === '0) begin
      n_err++;
      $display("FAIL mid_reset pre: busy=%0b count=%0d expected busy 1 and count nonzero", bus.busy, bus.match_count);
    end
    bus.start = 1'b1;
    reset_L = 1'b0;
    @(negedge clock);
    check_idle_zero("mid_reset");
    bus.start = 1'b0;
    reset_L = 1'b1;
    done_cnt = 0;
    repeat (25) begin
      @(negedge clock);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL mid_reset spurious activity: got %0d cycles expected 0", done_cnt); end
    run_search("after_mid_reset", 8'h00, 6, model(8'h00, 6));
  endtask

  task automatic test_start_held();
    exp_t       e, x;
    logic [7:0] p0;
    int         cyc, pulses, busy_after;
    fill_mem_random();
    p0 = {mem[2], mem[3], mem[4], mem[5]};
    e  = model(p0, 12);
    bus.start = 1'b1; bus.pattern = p0; bus.last_addr = ADDR_W'(12);
    sb_q.push_back(e);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      bus.pattern   = 8'($urandom);
      bus.last_addr = ADDR_W'($urandom_range(3, 50));
    end while (bus.done !== 1'b1 && cyc < 40);
    x = sb_q.pop_front();
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL start_held timeout: done not seen within %0d cycles", cyc);
    end else begin
      n_cmp++; if (cyc !== x.latency) begin n_err++; $display("FAIL start_held latency: got %0d expected %0d", cyc, x.latency); end
      n_cmp++;
      if (bus.found !== x.found || bus.first_addr !== x.first || bus.match_count !== x.count) begin
        n_err++;
        $display("FAIL start_held result: got %0b/%0d/%0d expected %0b/%0d/%0d",
                 bus.found, bus.first_addr, bus.match_count, x.found, x.first, x.count);
      end
    end
    @(negedge clock);
    bus.start = 1'b0;
    pulses = 0; busy_after = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done === 1'b1) pulses++;
      if (bus.busy === 1'b1) busy_after++;
    end
    n_cmp++; if (pulses !== 0 || busy_after !== 0) begin n_err++; $display("FAIL start_held restart: done=%0d busy=%0d cycles expected 0", pulses, busy_after); end
  endtask

`ifdef NUC_SEARCH_ABORT_EN
  task automatic test_abort();
    exp_t       e, x;
    logic [7:0] pat;
    int         cyc;
    fill_mem_random();
    pat = {mem[1], mem[2], mem[3], mem[4]};
    e = model(pat, 5);
    e.latency = 7;
    bus.start = 1'b1; bus.pattern = pat; bus.last_addr = ADDR_W'(100);
    sb_q.push_back(e);
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.nuc_addr !== ADDR_W'(5) && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    bus.abort = 1'b1;
    @(negedge clock);
    cyc++;
    bus.abort = 1'b0;
    x = sb_q.pop_front();
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL abort state: done=%0b busy=%0b expected 1/0", bus.done, bus.busy); end
    n_cmp++; if (cyc !== x.latency) begin n_err++; $display("FAIL abort latency: got %0d expected %0d", cyc, x.latency); end
    n_cmp++;
    if (bus.found !== x.found || bus.first_addr !== x.first || bus.match_count !== x.count) begin
      n_err++;
      $display("FAIL abort result: got %0b/%0d/%0d expected %0b/%0d/%0d",
               bus.found, bus.first_addr, bus.match_count, x.found, x.first, x.count);
    end
    @(negedge clock);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.last_addr = '0;
`ifdef NUC_SEARCH_ABORT_EN
    bus.abort = 1'b0;
`endif
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    @(negedge clock);
    test_reset();
    test_acgt();
    test_overlap();
    test_short();
    test_random();
    test_reset_mid_scan();
    test_start_held();
`ifdef NUC_SEARCH_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
